// File: rtl/mmio_uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Default bus addresses.
  localparam logic [7:0] TX_ADDR_DEF   = 8'hFE;
  localparam logic [7:0] STAT_ADDR_DEF = 8'hFD;

  // Bit positions inside the status byte.
  localparam int STAT_BUSY = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVF  = 2;

  // Assemble the status byte returned on the load path.
  function automatic logic [7:0] pack_status(input logic ovf, input logic full,
                                             input logic busy);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_BUSY] = busy;
    s[STAT_FULL] = full;
    s[STAT_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_if.sv
// CPU store/load bus as seen by the UART transmitter.
interface mmio_uart_tx_if;
  logic       cpu_tick;
  logic [7:0] Address;
  logic       we;
  logic [7:0] RegData;
  logic       rd_hit;
  logic [7:0] rd_data;

  // CPU side drives the address/store path and reads status back.
  modport master (
    output cpu_tick, Address, we, RegData,
    input  rd_hit, rd_data
  );

  // Peripheral side decodes stores and answers status loads.
  modport slave (
    input  cpu_tick, Address, we, RegData,
    output rd_hit, rd_data
  );
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous TX byte queue; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module mmio_uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  // Pointer control; the caller guarantees push/pop are legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks them.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: decodes CPU stores into a byte
// queue, serialises queued bytes on txd, and reports status on loads.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int         CLK_HZ     = 50_000_000,
  parameter int         BAUD       = 115200,
  parameter logic [7:0] TX_ADDR    = TX_ADDR_DEF,
  parameter logic [7:0] STAT_ADDR  = STAT_ADDR_DEF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mmio_uart_tx_if.slave     bus,
  output logic              txd,
  output logic              busy
);
  localparam int DATA_W   = 8;
  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  tx_state_t          r_state;
  logic [CW-1:0]      r_baud;
  logic [2:0]         r_bit_idx;
  logic [DATA_W-1:0]  r_shift;
  logic               r_txd;
  logic               r_busy;
  logic               r_ovf;

  logic               w_wr_tx;
  logic               w_wr_stat;
  logic               w_baud_end;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [DATA_W-1:0]  w_fifo_dout;

  // Bus decode: only a store qualified by the CPU tick does anything.
  assign w_wr_tx   = bus.cpu_tick & bus.we & (bus.Address == TX_ADDR);
  assign w_wr_stat = bus.cpu_tick & bus.we & (bus.Address == STAT_ADDR);

  assign w_baud_end = (r_baud == BAUD_LAST);

  // A byte leaves the queue when the line is idle, or at the very end of a
  // stop bit so the next start bit follows with no idle gap.
  assign w_pop = !w_empty &&
                 ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

  // A full queue still takes the byte if a slot frees in the same cycle.
  assign w_push = w_wr_tx & (!w_full | w_pop);

  // Status load path is combinational from the address and registered flags.
  assign bus.rd_hit  = (bus.Address == STAT_ADDR);
  assign bus.rd_data = bus.rd_hit ? pack_status(r_ovf, w_full, r_busy) : 8'h00;

  assign txd  = r_txd;
  assign busy = r_busy;

  mmio_uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (bus.RegData),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky overflow: set by a dropped byte, cleared by any store to status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_wr_stat) begin
      r_ovf <= 1'b0;
    end else if (w_wr_tx && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

  // Frame sequencer with baud counter; txd and busy are registered from the
  // current state, so every bit boundary appears one clock after the state
  // change and all bits keep an exact BAUD_DIV length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= (r_state != IDLE) || !w_empty;

      if (r_state == IDLE) begin
        r_baud <= '0;
      end else begin
        r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) r_state <= START;
        end
        START: begin
          r_txd <= 1'b0;
          if (w_baud_end) begin
            r_state   <= DATA;
            r_bit_idx <= '0;
          end
        end
        DATA: begin
          r_txd <= r_shift[0];
          if (w_baud_end) begin
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          r_txd <= 1'b1;
          if (w_baud_end) begin
            r_state <= w_pop ? START : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
        end
      endcase
    end
  end

  // Shift register: loaded on pop, advanced LSB-first at each data bit end.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_shift <= w_fifo_dout;
    end else if ((r_state == DATA) && w_baud_end) begin
      r_shift <= {1'b0, r_shift[DATA_W-1:1]};
    end
  end

endmodule
